// File: rtl/key_scan_ctrl_if.sv
// Board-side signal bundle for the key scanner: raw key/lamp inputs in,
// debounced key events and multiplexed 7-segment decoder drive out.
interface key_scan_ctrl_if;
  logic [15:0] in_N;
  logic        clear;
  logic        lamp_test_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;
  logic        key_down;
  logic        gs_n;
  logic [3:0]  bcd;
  logic [1:0]  dig_sel_n;
  logic        bi_n;
  logic        lt_n;

  modport master (
    output in_N, clear, lamp_test_n,
    input  key_code, key_valid, key_release, key_down, gs_n,
    input  bcd, dig_sel_n, bi_n, lt_n
  );

  modport slave (
    input  in_N, clear, lamp_test_n,
    output key_code, key_valid, key_release, key_down, gs_n,
    output bcd, dig_sel_n, bi_n, lt_n
  );
endinterface

// File: rtl/key_scan_ctrl.sv
// Synchronises and debounces 16 active-low keys, latches the highest-priority
// key, and time-multiplexes it as two decimal digits onto one BCD decoder.
module key_scan_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  key_scan_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [15:0]   key_meta, key_sync;
  logic          lt_meta, lt_sync;
  logic [3:0]    code;
  logic          act;
  logic [1:0]    state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    key_code_q, key_code_nxt;
  logic          shown, shown_nxt;
  logic          valid_nxt, release_nxt;
  logic          key_valid_q, key_release_q, key_down_q, gs_n_q;
  logic [SW-1:0] scan_cnt, scan_nxt;
  logic          digit, digit_nxt;
  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    bcd_q, bcd_nxt;
  logic [1:0]    dig_q, dig_nxt;
  logic          bi_q, bi_nxt;

  // Later (higher) indices overwrite earlier ones, so bit 15 has priority.
  always_comb begin
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!key_sync[i]) code = 4'(i);
    end
    act = ~&key_sync;
  end

  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    cnt_nxt      = cnt;
    key_code_nxt = key_code_q;
    shown_nxt    = shown;
    valid_nxt    = 1'b0;
    release_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (act) begin
          state_nxt = ST_DEBOUNCE;
          cand_nxt  = code;
          cnt_nxt   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!act) begin
          state_nxt = ST_IDLE;
        end else if (code != cand) begin
          cand_nxt = code;
          cnt_nxt  = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt    = ST_HELD;
          key_code_nxt = cand;
          shown_nxt    = 1'b1;
          valid_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (act && code != key_code_q) begin
          state_nxt = ST_DEBOUNCE;
          cand_nxt  = code;
          cnt_nxt   = '0;
        end else if (!act) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (act) begin
          if (code == key_code_q) begin
            state_nxt = ST_HELD;
          end else begin
            state_nxt = ST_DEBOUNCE;
            cand_nxt  = code;
            cnt_nxt   = '0;
          end
        end else if (cnt == DEB_LAST) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
    // A press accepted on the same edge takes precedence over clear.
    if (bus.clear && !valid_nxt) begin
      key_code_nxt = '0;
      shown_nxt    = 1'b0;
    end
  end

  // Display fields are derived from next-state values so they move together.
  always_comb begin
    scan_nxt  = scan_cnt + 1'b1;
    digit_nxt = digit;
    if (scan_cnt == SCAN_LAST) begin
      scan_nxt  = '0;
      digit_nxt = ~digit;
    end
    tens    = (key_code_nxt >= 4'd10);
    ones    = tens ? (key_code_nxt - 4'd10) : key_code_nxt;
    bcd_nxt = digit_nxt ? {3'b000, tens} : ones;
    dig_nxt = digit_nxt ? 2'b01 : 2'b10;
    bi_nxt  = shown_nxt && !(digit_nxt && !tens);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta      <= '1;
      key_sync      <= '1;
      lt_meta       <= 1'b1;
      lt_sync       <= 1'b1;
      state         <= ST_IDLE;
      cand          <= '0;
      cnt           <= '0;
      key_code_q    <= '0;
      shown         <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_down_q    <= 1'b0;
      gs_n_q        <= 1'b1;
      scan_cnt      <= '0;
      digit         <= 1'b0;
      bcd_q         <= '0;
      dig_q         <= 2'b10;
      bi_q          <= 1'b0;
    end else begin
      key_meta      <= bus.in_N;
      key_sync      <= key_meta;
      lt_meta       <= bus.lamp_test_n;
      lt_sync       <= lt_meta;
      state         <= state_nxt;
      cand          <= cand_nxt;
      cnt           <= cnt_nxt;
      key_code_q    <= key_code_nxt;
      shown         <= shown_nxt;
      key_valid_q   <= valid_nxt;
      key_release_q <= release_nxt;
      key_down_q    <= (state_nxt == ST_HELD) || (state_nxt == ST_RELEASE);
      gs_n_q        <= !((state_nxt == ST_HELD) || (state_nxt == ST_RELEASE));
      scan_cnt      <= scan_nxt;
      digit         <= digit_nxt;
      bcd_q         <= bcd_nxt;
      dig_q         <= dig_nxt;
      bi_q          <= bi_nxt;
    end
  end

  assign bus.key_code    = key_code_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_release = key_release_q;
  assign bus.key_down    = key_down_q;
  assign bus.gs_n        = gs_n_q;
  assign bus.bcd         = bcd_q;
  assign bus.dig_sel_n   = dig_q;
  assign bus.bi_n        = bi_q;
  assign bus.lt_n        = lt_sync;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: directed scenarios with literal expectations plus
// randomized key traffic checked every cycle against a run-length key model.
module tb_key_scan_ctrl;

  localparam int DEB  = 4;
  localparam int SDIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  key_scan_ctrl_if bus();

  key_scan_ctrl #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: keys are accepted after DEB+1 identical synchronised
  // samples, released after DEB+1 consecutive idle samples.
  logic [15:0] m_meta = 16'hffff;
  logic [15:0] m_sync = 16'hffff;
  logic        m_lt1  = 1'b1;
  logic        m_lt   = 1'b1;
  int          m_cand = 0, m_run = 0, m_relrun = 0, m_kc = 0, m_k = 0;
  bit          m_pending = 0, m_down = 0, m_shown = 0, m_valid = 0, m_release = 0;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin : model_and_compare
    logic [15:0] smp_in;
    logic        smp_clr;
    logic        smp_lamp;
    int          s;
    int          digit;
    int          exp_bcd;
    bit          exp_bi;
    smp_in   = bus.in_N;
    smp_clr  = bus.clear;
    smp_lamp = bus.lamp_test_n;
    if (!rst_n) begin
      m_meta = 16'hffff; m_sync = 16'hffff; m_lt1 = 1'b1; m_lt = 1'b1;
      m_cand = 0; m_run = 0; m_relrun = 0; m_kc = 0; m_k = 0;
      m_pending = 0; m_down = 0; m_shown = 0; m_valid = 0; m_release = 0;
    end else begin
      s = -1;
      for (int i = 0; i < 16; i++) if (!m_sync[i]) s = i;
      m_sync = m_meta; m_meta = smp_in;
      m_lt = m_lt1; m_lt1 = smp_lamp;
      m_valid = 0; m_release = 0;
      if (s >= 0) begin
        m_relrun = 0;
        if (!(m_down && s == m_kc)) begin
          if (m_pending && s == m_cand) begin
            m_run++;
            if (m_run == DEB + 1) begin
              m_kc = m_cand; m_valid = 1; m_shown = 1; m_down = 1; m_pending = 0;
            end
          end else begin
            m_pending = 1; m_cand = s; m_run = 1; m_down = 0;
          end
        end
      end else begin
        m_pending = 0;
        if (m_down) begin
          m_relrun++;
          if (m_relrun == DEB + 1) begin
            m_release = 1; m_down = 0;
          end
        end
      end
      if (smp_clr && !m_valid) begin
        m_kc = 0; m_shown = 0;
      end
      m_k++;
    end
    #1;
    digit   = (m_k / SDIV) % 2;
    exp_bcd = (digit == 1) ? (m_kc / 10) : (m_kc % 10);
    exp_bi  = m_shown && !(digit == 1 && m_kc < 10);
    check_output("key_code", 16'(bus.key_code), 16'(m_kc));
    check_output("key_valid", 16'(bus.key_valid), 16'(m_valid));
    check_output("key_release", 16'(bus.key_release), 16'(m_release));
    check_output("key_down", 16'(bus.key_down), 16'(m_down));
    check_output("gs_n", 16'(bus.gs_n), 16'(!m_down));
    check_output("bcd", 16'(bus.bcd), 16'(exp_bcd));
    check_output("dig_sel_n", 16'(bus.dig_sel_n), (digit == 1) ? 16'd1 : 16'd2);
    check_output("bi_n", 16'(bus.bi_n), 16'(exp_bi));
    check_output("lt_n", 16'(bus.lt_n), 16'(m_lt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [15:0] pat, input logic clr, input logic lamp);
    @(negedge clk);
    bus.in_N        = pat;
    bus.clear       = clr;
    bus.lamp_test_n = lamp;
  endtask

  // what: 0 key_valid, 1 key_release, 2 tens digit selected, 3 ones digit selected
  task automatic wait_for(input string name, input int what, input int max_cycles);
    bit seen = 0;
    for (int n = 0; n < max_cycles && !seen; n++) begin
      step(1);
      case (what)
        0:       seen = bus.key_valid;
        1:       seen = bus.key_release;
        2:       seen = (bus.dig_sel_n == 2'b01);
        default: seen = (bus.dig_sel_n == 2'b10);
      endcase
    end
    check_output(name, 16'(seen), 16'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [15:0] pat;
    logic [15:0] one;
    int          hold;
    int          sel;
    int          pulses;
    int          bi_high;
    one  = 16'h0001;
    hold = 0;
    bus.in_N        = 16'hffff;
    bus.clear       = 1'b0;
    bus.lamp_test_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("rst_key_valid", 16'(bus.key_valid), 16'd0);
    check_output("rst_key_code", 16'(bus.key_code), 16'd0);
    check_output("rst_gs_n", 16'(bus.gs_n), 16'd1);
    check_output("rst_dig_sel_n", 16'(bus.dig_sel_n), 16'd2);
    check_output("rst_bi_n", 16'(bus.bi_n), 16'd0);
    check_output("rst_lt_n", 16'(bus.lt_n), 16'd1);

    // Key 11 held from the first edge after reset
    rst_n    = 1'b1;
    bus.in_N = ~16'h0800;
    step(6);
    check_output("k11_valid_early", 16'(bus.key_valid), 16'd0);
    step(1);
    check_output("k11_valid", 16'(bus.key_valid), 16'd1);
    check_output("k11_code", 16'(bus.key_code), 16'd11);
    check_output("k11_bcd", 16'(bus.bcd), 16'd1);
    check_output("k11_bi_n", 16'(bus.bi_n), 16'd1);
    step(1);
    check_output("k11_valid_drop", 16'(bus.key_valid), 16'd0);
    check_output("k11_down", 16'(bus.key_down), 16'd1);

    // Keys 5 and 11 together, then 11 released
    apply_stimulus(~16'h0820, 1'b0, 1'b1);
    step(4);
    apply_stimulus(~16'h0020, 1'b0, 1'b1);
    wait_for("k5_valid_seen", 0, 15);
    check_output("k5_code", 16'(bus.key_code), 16'd5);
    wait_for("k5_tens_seen", 2, 10);
    check_output("k5_tens_bi_n", 16'(bus.bi_n), 16'd0);
    wait_for("k5_ones_seen", 3, 10);
    check_output("k5_ones_bcd", 16'(bus.bcd), 16'd5);
    check_output("k5_ones_bi_n", 16'(bus.bi_n), 16'd1);

    // Release, clear the display, then a short glitch on key 3
    apply_stimulus(16'hffff, 1'b0, 1'b1);
    wait_for("k5_release_seen", 1, 15);
    apply_stimulus(16'hffff, 1'b1, 1'b1);
    apply_stimulus(16'hffff, 1'b0, 1'b1);
    step(1);
    check_output("clr_bi_n", 16'(bus.bi_n), 16'd0);
    repeat (3) apply_stimulus(~16'h0008, 1'b0, 1'b1);
    apply_stimulus(16'hffff, 1'b0, 1'b1);
    pulses  = 0;
    bi_high = 0;
    for (int n = 0; n < 16; n++) begin
      step(1);
      if (bus.key_valid) pulses++;
      if (bus.bi_n) bi_high++;
    end
    check_output("glitch_pulses", 16'(pulses), 16'd0);
    check_output("glitch_bi_high", 16'(bi_high), 16'd0);
    check_output("glitch_down", 16'(bus.key_down), 16'd0);

    // Key 7 held then released
    apply_stimulus(~16'h0080, 1'b0, 1'b1);
    wait_for("k7_valid_seen", 0, 15);
    check_output("k7_code", 16'(bus.key_code), 16'd7);
    step(2);
    apply_stimulus(16'hffff, 1'b0, 1'b1);
    step(6);
    check_output("k7_release_early", 16'(bus.key_release), 16'd0);
    check_output("k7_down_held", 16'(bus.key_down), 16'd1);
    step(1);
    check_output("k7_release", 16'(bus.key_release), 16'd1);
    check_output("k7_down_fall", 16'(bus.key_down), 16'd0);
    step(1);
    check_output("k7_release_drop", 16'(bus.key_release), 16'd0);
    wait_for("k7_ones_seen", 3, 10);
    check_output("k7_ones_bcd", 16'(bus.bcd), 16'd7);
    check_output("k7_ones_bi_n", 16'(bus.bi_n), 16'd1);

    // Asynchronous reset in the middle of debouncing key 2
    apply_stimulus(~16'h0004, 1'b0, 1'b1);
    step(4);
    #1 rst_n = 1'b0;
    #1;
    check_output("arst_key_code", 16'(bus.key_code), 16'd0);
    check_output("arst_key_down", 16'(bus.key_down), 16'd0);
    check_output("arst_gs_n", 16'(bus.gs_n), 16'd1);
    check_output("arst_bcd", 16'(bus.bcd), 16'd0);
    check_output("arst_dig_sel_n", 16'(bus.dig_sel_n), 16'd2);
    check_output("arst_bi_n", 16'(bus.bi_n), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(6);
    check_output("k2_valid_early", 16'(bus.key_valid), 16'd0);
    step(1);
    check_output("k2_valid", 16'(bus.key_valid), 16'd1);
    check_output("k2_code", 16'(bus.key_code), 16'd2);

    // Key 9 accepted, then cleared while still latched
    apply_stimulus(~16'h0200, 1'b0, 1'b1);
    wait_for("k9_valid_seen", 0, 20);
    check_output("k9_code", 16'(bus.key_code), 16'd9);
    apply_stimulus(16'hffff, 1'b1, 1'b1);
    step(1);
    check_output("k9_clr_code", 16'(bus.key_code), 16'd0);
    check_output("k9_clr_bi_n", 16'(bus.bi_n), 16'd0);
    apply_stimulus(16'hffff, 1'b0, 1'b1);
    bi_high = 0;
    for (int n = 0; n < 2 * SDIV; n++) begin
      step(1);
      if (bus.bi_n) bi_high++;
    end
    check_output("k9_blank_both", 16'(bi_high), 16'd0);

    // Lamp test passes through two synchroniser stages
    apply_stimulus(16'hffff, 1'b0, 1'b0);
    step(1);
    check_output("lt_first_edge", 16'(bus.lt_n), 16'd1);
    step(1);
    check_output("lt_second_edge", 16'(bus.lt_n), 16'd0);
    apply_stimulus(16'hffff, 1'b0, 1'b1);

    // Randomized key traffic with occasional clear, lamp test and reset
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0:       pat = 16'hffff;
          1, 2:    pat = ~(one << $urandom_range(0, 15));
          3:       pat = ~((one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15)));
          default: pat = 16'($urandom);
        endcase
        hold = $urandom_range(1, 12);
      end
      hold--;
      apply_stimulus(pat, ($urandom_range(0, 59) == 0), ($urandom_range(0, 29) != 0));
      if ($urandom_range(0, 799) == 0) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
